bit32_serial_subtractor: RTL and testbench

Multi-cycle 32-bit subtractor computing `a - b` one digit per clock through a single DIGIT_W-wide ripple stage, low digit first. It is the subtract-direction counterpart of the team's 32-bit ripple-carry adder and is intended for datapaths that trade latency for area. Operands are captured on a start handshake and the result is held stable until the next operation.

---
 rtl/bit32_serial_subtractor_if.sv | 21 ++
 rtl/bit32_serial_subtractor.sv | 125 ++++++++++++
 tb/tb_bit32_serial_subtractor.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bit32_serial_subtractor_if.sv
// Operand/result bundle for bit32_serial_subtractor.
// The optional zero flag exists only when SUB_ZERO_FLAG_EN is defined.
interface bit32_serial_subtractor_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] diff;
  logic        bout;
  logic        ovf;
  logic        busy;
  logic        done;
`ifdef SUB_ZERO_FLAG_EN
  logic        zero;

  modport master (output start, a, b, input diff, bout, ovf, busy, done, zero);
  modport slave  (input start, a, b, output diff, bout, ovf, busy, done, zero);
`else
  modport master (output start, a, b, input diff, bout, ovf, busy, done);
  modport slave  (input start, a, b, output diff, bout, ovf, busy, done);
`endif
endinterface

// File: rtl/bit32_serial_subtractor.sv
// Digit-serial 32-bit subtractor, a - b, low digit first through one DIGIT_W-wide stage.
// Optional macro SUB_ZERO_FLAG_EN adds a registered zero-result flag.
//
// state   | meaning
// IDLE    | waiting for start, results held
// RUN     | one digit per edge, digit cnt
// DONE    | one-cycle result-valid pulse, start re-accepted
module bit32_serial_subtractor #(
  parameter int DIGIT_W = 4
) (
  input logic                      clk,
  input logic                      rst,
  bit32_serial_subtractor_if.slave bus
);

  localparam int N  = 32 / DIGIT_W;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = DIGIT_W + 1;

  if (!(DIGIT_W == 1 || DIGIT_W == 2 || DIGIT_W == 4 ||
        DIGIT_W == 8 || DIGIT_W == 16 || DIGIT_W == 32)) begin : g_bad_digit_w
    $error("bit32_serial_subtractor: DIGIT_W must be 1, 2, 4, 8, 16 or 32");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [31:0]     r_ra;
  logic [31:0]     r_rb;
  logic [31:0]     r_res;
  logic [CW-1:0]   r_cnt;
  logic            r_c;
  logic [31:0]     r_diff;
  logic            r_bout;
  logic            r_ovf;

  logic            w_accept;
  logic            w_last;
  logic [4:0]      w_base;
  logic [DIGIT_W-1:0] w_a_dig;
  logic [DIGIT_W-1:0] w_b_dig;
  logic [SW-1:0]   w_sum;
  logic [31:0]     w_res_next;
  logic            w_ovf;

  assign w_accept = bus.start && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_last   = (r_cnt == CW'(N - 1));
  assign w_base   = 5'(r_cnt) * 5'(DIGIT_W);
  assign w_a_dig  = r_ra[w_base +: DIGIT_W];
  assign w_b_dig  = r_rb[w_base +: DIGIT_W];
  // a - b as a + ~b + 1: the carry flop is seeded with 1 at accept
  assign w_sum    = {1'b0, w_a_dig} + {1'b0, ~w_b_dig} + SW'(r_c);

  always_comb begin
    w_res_next = r_res;
    w_res_next[w_base +: DIGIT_W] = w_sum[DIGIT_W-1:0];
  end

  assign w_ovf = (r_ra[31] != r_rb[31]) && (w_res_next[31] != r_ra[31]);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (bus.start) w_state_next = ST_RUN;
      ST_RUN:  if (w_last)    w_state_next = ST_DONE;
      ST_DONE: w_state_next = bus.start ? ST_RUN : ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ra   <= '0;
      r_rb   <= '0;
      r_res  <= '0;
      r_cnt  <= '0;
      r_c    <= 1'b0;
      r_diff <= '0;
      r_bout <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_accept) begin
      r_ra  <= bus.a;
      r_rb  <= bus.b;
      r_c   <= 1'b1;
      r_cnt <= '0;
    end else if (r_state == ST_RUN) begin
      r_res <= w_res_next;
      r_c   <= w_sum[DIGIT_W];
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        r_diff <= w_res_next;
        r_bout <= ~w_sum[DIGIT_W];
        r_ovf  <= w_ovf;
      end
    end
  end

`ifdef SUB_ZERO_FLAG_EN
  logic r_zero;

  always_ff @(posedge clk) begin
    if (rst)                              r_zero <= 1'b0;
    else if (!w_accept && r_state == ST_RUN && w_last) r_zero <= (w_res_next == 32'd0);
  end

  assign bus.zero = r_zero;
`endif

  assign bus.diff = r_diff;
  assign bus.bout = r_bout;
  assign bus.ovf  = r_ovf;
  assign bus.busy = (r_state == ST_RUN);
  assign bus.done = (r_state == ST_DONE);

endmodule

// File: tb/tb_bit32_serial_subtractor.sv
// Scoreboard bench: directed vectors on DIGIT_W=4, random sweeps on DIGIT_W=1 and 32.
module tb_bit32_serial_subtractor;

  typedef struct {
    logic [31:0] d;
    logic        bo;
    logic        ov;
    logic        z;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   n_done4 = 0;

  exp_t q4[$];
  exp_t q1[$];
  exp_t q32[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bit32_serial_subtractor_if if4 ();
  bit32_serial_subtractor_if if1 ();
  bit32_serial_subtractor_if if32 ();

  bit32_serial_subtractor #(.DIGIT_W(4))  u_dut4  (.clk(clk), .rst(rst), .bus(if4));
  bit32_serial_subtractor #(.DIGIT_W(1))  u_dut1  (.clk(clk), .rst(rst), .bus(if1));
  bit32_serial_subtractor #(.DIGIT_W(32)) u_dut32 (.clk(clk), .rst(rst), .bus(if32));

  logic z4, z1, z32;
`ifdef SUB_ZERO_FLAG_EN
  assign z4  = if4.zero;
  assign z1  = if1.zero;
  assign z32 = if32.zero;
`else
  assign z4  = 1'b0;
  assign z1  = 1'b0;
  assign z32 = 1'b0;
`endif

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic exp_t hand(input logic [31:0] d, input logic bo, input logic ov);
    exp_t e;
    e.d = d; e.bo = bo; e.ov = ov; e.z = (d == 32'd0); e.cyc = 0;
    return e;
  endfunction

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] d;
    d = a - b;
    return hand(d, a < b, (a[31] != b[31]) && (d[31] != a[31]));
  endfunction

  task automatic check_done(input string tag, input exp_t e, input logic [31:0] d,
                            input logic bo, input logic ov, input logic z, input int lat);
    cmp({tag, "_diff"}, d, e.d);
    cmp({tag, "_bout"}, {31'd0, bo}, {31'd0, e.bo});
    cmp({tag, "_ovf"},  {31'd0, ov}, {31'd0, e.ov});
    cmp({tag, "_latency"}, cyc - e.cyc, lat);
`ifdef SUB_ZERO_FLAG_EN
    cmp({tag, "_zero"}, {31'd0, z}, {31'd0, e.z});
`endif
  endtask

  task automatic unexpected(input string tag);
    checks++;
    errors++;
    $display("FAIL %s_unexpected_done actual=done required=no_done", tag);
  endtask

  always @(negedge clk) begin
    if (if4.done) begin
      n_done4++;
      if (q4.size() == 0) unexpected("w4");
      else check_done("w4", q4.pop_front(), if4.diff, if4.bout, if4.ovf, z4, 8);
    end
    if (if1.done) begin
      if (q1.size() == 0) unexpected("w1");
      else check_done("w1", q1.pop_front(), if1.diff, if1.bout, if1.ovf, z1, 32);
    end
    if (if32.done) begin
      if (q32.size() == 0) unexpected("w32");
      else check_done("w32", q32.pop_front(), if32.diff, if32.bout, if32.ovf, z32, 1);
    end
  end

  function automatic logic dn(input int w);
    case (w)
      1:       return if1.done;
      32:      return if32.done;
      default: return if4.done;
    endcase
  endfunction

  // Called at a negedge; returns just after the accepting edge with start dropped and
  // the operand pins scrambled so any late capture would corrupt the result.
  task automatic issue(input int w, input logic [31:0] a, input logic [31:0] b, input exp_t e);
    case (w)
      1:       begin if1.start = 1'b1;  if1.a = a;  if1.b = b;  end
      32:      begin if32.start = 1'b1; if32.a = a; if32.b = b; end
      default: begin if4.start = 1'b1;  if4.a = a;  if4.b = b;  end
    endcase
    @(posedge clk);
    #1;
    e.cyc = cyc;
    case (w)
      1:       begin q1.push_back(e);  if1.start = 1'b0;  if1.a = ~a;  if1.b = b ^ 32'h5A5A5A5A;  end
      32:      begin q32.push_back(e); if32.start = 1'b0; if32.a = ~a; if32.b = b ^ 32'h5A5A5A5A; end
      default: begin q4.push_back(e);  if4.start = 1'b0;  if4.a = ~a;  if4.b = b ^ 32'h5A5A5A5A;  end
    endcase
  endtask

  task automatic wait_done(input int w, input int budget, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!dn(w) && n < budget);
    checks++;
    if (!dn(w)) begin
      errors++;
      $display("FAIL %s_timeout actual=no_done required=done_within_%0d", tag, budget);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int seen;
    logic [31:0] ra, rb;
    if4.start = 0;  if4.a = 0;  if4.b = 0;
    if1.start = 0;  if1.a = 0;  if1.b = 0;
    if32.start = 0; if32.a = 0; if32.b = 0;

    // Reset, with start held high to show reset wins
    if4.start = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    cmp("rst_diff", if4.diff, 32'd0);
    cmp("rst_bout", {31'd0, if4.bout}, 32'd0);
    cmp("rst_ovf",  {31'd0, if4.ovf},  32'd0);
    cmp("rst_busy", {31'd0, if4.busy}, 32'd0);
    cmp("rst_done", {31'd0, if4.done}, 32'd0);
    cmp("rst_zero", {31'd0, z4}, 32'd0);
    if4.start = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // 300 - 200, busy must be high for exactly 8 cycles
    issue(4, 32'd300, 32'd200, hand(32'd100, 1'b0, 1'b0));
    n = 0;
    @(negedge clk);
    while (if4.busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    cmp("busy_cycles", n, 32'd8);
    cmp("done_after_busy", {31'd0, if4.done}, 32'd1);

    @(negedge clk);
    issue(4, 32'd100, 32'd200, hand(32'hFFFFFF9C, 1'b1, 1'b0));
    wait_done(4, 20, "w4_borrow");
    @(negedge clk);
    issue(4, 32'h80000000, 32'd1, hand(32'h7FFFFFFF, 1'b0, 1'b1));
    wait_done(4, 20, "w4_ovf");

    // Equal operands, then back-to-back issue in the DONE cycle
    @(negedge clk);
    issue(4, 32'd5, 32'd5, hand(32'd0, 1'b0, 1'b0));
    wait_done(4, 20, "w4_equal");
    issue(4, 32'd6, 32'd5, hand(32'd1, 1'b0, 1'b0));
    wait_done(4, 20, "w4_b2b");

    // Start during RUN must be ignored
    @(negedge clk);
    issue(4, 32'd7, 32'd3, hand(32'd4, 1'b0, 1'b0));
    repeat (3) @(negedge clk);
    if4.start = 1'b1; if4.a = 32'd100; if4.b = 32'd1;
    @(posedge clk);
    #1 if4.start = 1'b0;
    wait_done(4, 20, "w4_ignore");
    repeat (12) @(negedge clk);
    cmp("ignore_queue_empty", q4.size(), 32'd0);

    // Reset sampled at E4 of a running operation
    issue(4, 32'd9, 32'd1, hand(32'd8, 1'b0, 1'b0));
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    q4.delete();
    seen = n_done4;
    @(negedge clk);
    cmp("midrst_diff", if4.diff, 32'd0);
    cmp("midrst_bout", {31'd0, if4.bout}, 32'd0);
    cmp("midrst_ovf",  {31'd0, if4.ovf},  32'd0);
    cmp("midrst_busy", {31'd0, if4.busy}, 32'd0);
    repeat (12) @(negedge clk);
    cmp("midrst_no_done", n_done4, seen);

    // Random sweeps on the 1-bit and 32-bit digit variants, issued back to back
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          ra = (i == 0) ? 32'd0 : $urandom;
          rb = (i == 0) ? 32'd1 : $urandom;
          issue(1, ra, rb, model(ra, rb));
          wait_done(1, 40, "w1_rand");
        end
      end
      begin
        for (int i = 0; i < 1000; i++) begin
          ra = (i == 0) ? 32'h7FFFFFFF : $urandom;
          rb = (i == 0) ? 32'hFFFFFFFF : $urandom;
          issue(32, ra, rb, model(ra, rb));
          wait_done(32, 5, "w32_rand");
        end
      end
    join
    repeat (4) @(negedge clk);
    cmp("q1_empty", q1.size(), 32'd0);
    cmp("q32_empty", q32.size(), 32'd0);
    cmp("q4_empty", q4.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
